gray_conv_arbiter: RTL and testbench
====================================

// Module: gray_conv_arbiter
// PURPOSE
//  Shares one Gray-to-binary conversion core between N_REQ requesters.
//  - Round-robin arbitration picks one requester at a time.
//  - The winner's Gray word is captured, converted and registered.
//  - The result is returned with the requester ID over a valid/ready output port.
//  - Sits between multiple Gray-coded sources (counters, encoders, CDC pointers) and downstream binary logic.
// PARAMETERS
//  N_REQ   4   number of requesters (>=2)
//  WIDTH   4   Gray/binary word width (>=2)
//  ID_W    $clog2(N_REQ)   width of out_id (derived, not overridden)
// PORTS
//  clk        in   1              single clock; all logic rising-edge
//  rst        in   1              synchronous, active-high reset
//  req        in   N_REQ          per-requester conversion request
//  gray_in    in   N_REQ*WIDTH    Gray word of requester i in bits [i*WIDTH +: WIDTH]
//  gnt        out  N_REQ          one-hot grant; gray_in[i] sampled at the edge where gnt[i]=1
//  out_valid  out  1              converted result available
//  out_ready  in   1              downstream accepts result
//  out_bin    out  WIDTH          binary result
//  out_id     out  ID_W           index of requester that produced out_bin
//  busy       out  1              high in any state other than IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, gnt=0, out_valid=0, out_bin=0, out_id=0, busy=0, rr_ptr=N_REQ-1.
//  FSM states: IDLE -> CONV -> HOLD -> IDLE.
//  - IDLE:
//    - gnt is combinational: the first req[i] found searching from (rr_ptr+1) mod N_REQ upward, wrapping.
//    - gnt is never asserted outside IDLE.
//    - On the edge with any gnt: capture gray_q=gray_in[i], id_q=i, rr_ptr=i, then go to CONV.
//    - With no req: stay in IDLE.
//  - CONV:
//    - out_bin <= gray2bin(gray_q); out_id <= id_q; out_valid <= 1; go to HOLD.
//  - HOLD:
//    - out_valid, out_bin and out_id are held stable until out_valid&&out_ready.
//    - On that edge: out_valid <= 0; go to IDLE.
//  Latency:
//    - gnt in cycle 0; out_valid first high in cycle 2.
//    - Minimum 3 cycles per conversion with out_ready tied high.
//  Conversion: b[WIDTH-1]=g[WIDTH-1]; b[k]=b[k+1]^g[k] for k=WIDTH-2..0. Pure function, no truncation.
//  Requester rules:
//    - Hold req and gray_in stable until gnt[i] is seen.
//    - Drop req the cycle after gnt unless another conversion is wanted.
//    - req changes while in CONV/HOLD are ignored, not queued.
//  Fairness: a requester that is continuously asserted waits at most N_REQ-1 grants.
//  Simultaneous events: req arriving in the same cycle that HOLD completes is granted no earlier than the next IDLE cycle.
//  Reset mid-operation: captured word discarded, out_valid drops on the reset edge, no result is emitted.
//  rr_ptr wraps N_REQ-1 -> 0.
// STRUCTURE
//  - Package gray_conv_pkg:
//    - state enum {IDLE, CONV, HOLD};
//    - default N_REQ/WIDTH constants;
//    - function rr_pick(req, ptr).
//  - Sub-module gray2bin_core #(WIDTH):
//    - combinational Gray->binary XOR chain;
//    - single instance, fed from gray_q.
//  - Top: FSM, rr_ptr, capture and output registers.
// TESTING
//  1. Single request:
//     - req=0001, gray_in[0]=0010 -> gnt=0001 in cycle 0;
//     - out_valid in cycle 2 with out_bin=0011, out_id=0.
//  2. All requesters at once:
//     - req=1111 held, out_ready=1 -> grant order 0,1,2,3,0.
//     - Stimulus gray words 1000, 1011, 0111, 1111 -> results 1111, 1101, 0101, 1010.
//  3. Backpressure:
//     - out_ready=0 for 5 cycles in HOLD -> out_valid, out_bin and out_id stable; gnt=0.
//     - Release -> handshake in one cycle, then IDLE.
//  4. Fairness:
//     - req0 and req2 held continuously -> grants alternate 0,2,0,2.
//     - req1 asserted later is granted within 2 grants.
//  5. Exhaustive: each of the 16 Gray codes via requester 3 -> out_bin matches the reference function, out_id=3.
//  6. Reset in CONV and again in HOLD:
//     - out_valid=0 on the following cycle, rr_ptr back to N_REQ-1;
//     - the next req0+req1 grants req0 first.

Source files
------------

// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: shared state enum, default sizes and the round-robin pick function
package gray_conv_pkg;
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 4;
  function automatic int rr_pick(input logic [31:0] req, input int n, input int ptr);
    rr_pick = -1;
    for (int k = n; k >= 1; k--) begin
      int i;
      i = (ptr + k) % n;
      if (req[i]) rr_pick = i;
    end
  endfunction
endpackage

// File: rtl/gray_conv_arbiter_if.sv
// gray_conv_arbiter_if: request/grant bus plus valid/ready result port; master = requesters/sink, slave = arbiter
interface gray_conv_arbiter_if import gray_conv_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int ID_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ*WIDTH-1:0] gray_in;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_bin;
  logic [ID_W-1:0] out_id;
  logic busy;
  modport master(output req, gray_in, out_ready, input gnt, out_valid, out_bin, out_id, busy);
  modport slave(input req, gray_in, out_ready, output gnt, out_valid, out_bin, out_id, busy);
endinterface

// File: rtl/gray2bin_core.sv
// gray2bin_core: combinational Gray->binary; in gray, out bin (each bit is the XOR of all higher-or-equal Gray bits)
module gray2bin_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    assign bin[k] = ^gray[WIDTH-1:k];
  end
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin sharing of one Gray->binary core; ports clk, rst, bus (req/gray_in/gnt, out_valid/out_ready/out_bin/out_id, busy)
module gray_conv_arbiter import gray_conv_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int ID_W = $clog2(N_REQ)
) (
  input logic clk,
  input logic rst,
  gray_conv_arbiter_if.slave bus
);
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, oid_q, oid_d, pick_idx;
  logic [WIDTH-1:0] gray_q, gray_d, bin_q, bin_d, bin_w;
  logic valid_q, valid_d, hit;
  int pick;
  gray2bin_core #(.WIDTH(WIDTH)) u_core (.gray(gray_q), .bin(bin_w));
  always_comb begin
    pick = rr_pick(32'(bus.req), N_REQ, int'(rr_q));
    hit = (state_q == IDLE) && (pick >= 0);
    pick_idx = ID_W'(pick);
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    gray_d = gray_q;
    bin_d = bin_q;
    oid_d = oid_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (hit) begin
        state_d = CONV;
        gray_d = bus.gray_in[pick_idx*WIDTH +: WIDTH];
        id_d = pick_idx;
        rr_d = pick_idx;
      end
      CONV: begin
        state_d = HOLD;
        bin_d = bin_w;
        oid_d = id_q;
        valid_d = 1'b1;
      end
      HOLD: if (bus.out_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= ID_W'(N_REQ - 1);
      id_q <= '0;
      gray_q <= '0;
      bin_q <= '0;
      oid_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      gray_q <= gray_d;
      bin_q <= bin_d;
      oid_q <= oid_d;
      valid_q <= valid_d;
    end
  end
  assign bus.gnt = hit ? (N_REQ'(1) << pick_idx) : '0;
  assign bus.out_valid = valid_q;
  assign bus.out_bin = bin_q;
  assign bus.out_id = oid_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: scoreboard bench with a behavioural arbiter/converter model and queued requesters
module tb_gray_conv_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  typedef struct {int id; logic [W-1:0] bin;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gray_conv_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();
  gray_conv_arbiter #(.N_REQ(N), .WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gcyc = 0;
  int ptr = N - 1;
  bit outstanding = 0;
  bit rst_prev = 0;
  exp_t exp_q[$];
  int grant_log[$];
  logic [W-1:0] out_log[$];
  logic [W-1:0] words[N][$];
  logic [N-1:0] last_gnt = '0;
  function automatic int ref_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  initial forever begin
    int pk, gi;
    @(negedge clk);
    cyc++;
    if (rst) begin
      if (rst_prev) begin
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_out_bin", 32'(bus.out_bin), 0);
        chk("rst_out_id", 32'(bus.out_id), 0);
      end
      rst_prev = 1;
      ptr = N - 1;
      outstanding = 0;
      exp_q.delete();
      last_gnt = '0;
    end else begin
      rst_prev = 0;
      chk("out_valid", 32'(bus.out_valid), 32'(outstanding && (cyc >= gcyc + 2)));
      chk("busy", 32'(bus.busy), 32'(outstanding));
      pk = outstanding ? -1 : ref_pick(bus.req, ptr);
      chk("gnt", 32'(bus.gnt), pk >= 0 ? 32'(1) << pk : 32'(0));
      last_gnt = bus.gnt;
      gi = -1;
      for (int i = 0; i < N; i++) if (bus.gnt[i]) gi = i;
      if (gi >= 0) grant_log.push_back(gi);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_result", 32'(bus.out_valid), 0);
        else begin
          chk("out_bin", 32'(bus.out_bin), 32'(exp_q[0].bin));
          chk("out_id", 32'(bus.out_id), 32'(exp_q[0].id));
          if (bus.out_ready) begin
            out_log.push_back(bus.out_bin);
            void'(exp_q.pop_front());
            outstanding = 0;
          end
        end
      end
      if (pk >= 0) begin
        exp_q.push_back('{id: pk, bin: ref_g2b(bus.gray_in[pk*W +: W])});
        ptr = pk;
        outstanding = 1;
        gcyc = cyc;
      end
    end
  end
  task automatic step();
    logic [N-1:0] r;
    logic [N*W-1:0] g;
    @(posedge clk);
    #2;
    r = '0;
    g = '0;
    for (int i = 0; i < N; i++) begin
      if (last_gnt[i] && words[i].size() > 0) void'(words[i].pop_front());
      if (words[i].size() > 0) begin
        r[i] = 1'b1;
        g[i*W +: W] = words[i][0];
      end
    end
    bus.req = r;
    bus.gray_in = g;
  endtask
  function automatic bit pending();
    for (int i = 0; i < N; i++) if (words[i].size() > 0) return 1;
    return outstanding;
  endfunction
  task automatic wait_idle(input string name);
    int n = 0;
    while (pending() && n < 3000) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, 32'(n >= 3000), 0);
    step();
  endtask
  task automatic wait_on(input string name, input bit want_valid);
    int n = 0;
    while (!(want_valid ? bus.out_valid : bus.busy) && n < 100) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, 32'(n >= 100), 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    grant_log.delete();
    out_log.delete();
  endtask
  initial begin
    int n0, j;
    bus.req = '0;
    bus.gray_in = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    words[0].push_back(4'b0010);
    wait_idle("t1");
    chk("t1_grant", 32'(grant_log[0]), 0);
    chk("t1_bin", 32'(out_log[0]), 32'b0011);
    do_reset();
    words[0] = '{4'b1000, 4'b0000};
    words[1] = '{4'b1011};
    words[2] = '{4'b0111};
    words[3] = '{4'b1111};
    wait_idle("t2");
    chk("t2_grants", 32'(grant_log.size()), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("t2_order", 32'(grant_log[i]), 32'(i % N));
    if (out_log.size() >= 4) begin
      chk("t2_bin0", 32'(out_log[0]), 32'b1111);
      chk("t2_bin1", 32'(out_log[1]), 32'b1101);
      chk("t2_bin2", 32'(out_log[2]), 32'b0101);
      chk("t2_bin3", 32'(out_log[3]), 32'b1010);
    end else chk("t2_results", 32'(out_log.size()), 4);
    bus.out_ready = 1'b0;
    words[2].push_back(4'($urandom));
    wait_on("t3_valid", 1);
    words[1].push_back(4'($urandom));
    repeat (5) step();
    chk("t3_held_valid", 32'(bus.out_valid), 1);
    chk("t3_held_gnt", 32'(bus.gnt), 0);
    bus.out_ready = 1'b1;
    wait_idle("t3");
    do_reset();
    repeat (4) begin
      words[0].push_back(4'($urandom));
      words[2].push_back(4'($urandom));
    end
    n0 = 0;
    while (grant_log.size() < 2 && n0 < 100) begin
      step();
      n0++;
    end
    chk("t4_start_timeout", 32'(n0 >= 100), 0);
    n0 = grant_log.size();
    words[1].push_back(4'($urandom));
    wait_idle("t4");
    chk("t4_g0", 32'(grant_log[0]), 0);
    chk("t4_g1", 32'(grant_log[1]), 2);
    j = -1;
    for (int i = grant_log.size() - 1; i >= n0; i--) if (grant_log[i] == 1) j = i;
    chk("t4_fair", 32'(j >= n0 && j - n0 <= 2), 1);
    out_log.delete();
    for (int g = 0; g < 16; g++) words[3].push_back(4'(g));
    wait_idle("t5");
    chk("t5_count", 32'(out_log.size()), 16);
    words[0].push_back(4'($urandom));
    wait_on("t6_conv", 0);
    do_reset();
    bus.out_ready = 1'b0;
    words[1].push_back(4'($urandom));
    wait_on("t6_hold", 1);
    do_reset();
    bus.out_ready = 1'b1;
    words[0].push_back(4'($urandom));
    words[1].push_back(4'($urandom));
    wait_idle("t6");
    chk("t6_first", 32'(grant_log[0]), 0);
    chk("t6_second", 32'(grant_log[1]), 1);
    chk("t6_results", 32'(out_log.size()), 2);
    repeat (400) begin
      int i;
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      i = $urandom_range(0, N - 1);
      if (words[i].size() < 3 && $urandom_range(0, 2) == 0) words[i].push_back(4'($urandom));
      step();
    end
    bus.out_ready = 1'b1;
    wait_idle("rand");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
